// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI arbiter: state encoding, port indices,
// default timeout and the latched byte payload.
package oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_e;

    localparam int unsigned PORT0               = 0;
    localparam int unsigned PORT1               = 1;
    localparam int unsigned DATA_W              = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 4096;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              dc;
    } oled_byte_t;

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Requester handshakes and shared SPI byte-engine connection of the arbiter.
interface oled_spi_arbiter_if;
    import oled_pkg::*;

    logic              REQ0;
    logic              REQ1;
    logic [DATA_W-1:0] DAT0;
    logic [DATA_W-1:0] DAT1;
    logic              DC0;
    logic              DC1;
    logic              LOCK0;
    logic              LOCK1;
    logic              ACK0;
    logic              ACK1;
    logic              GNT0;
    logic              GNT1;
    logic              SPI_EN;
    logic [DATA_W-1:0] SPI_DATA;
    logic              SPI_FIN;
    logic              DC;
    logic              BUSY;
    logic              ERR;

    modport slave (
        input  REQ0, REQ1, DAT0, DAT1, DC0, DC1, LOCK0, LOCK1, SPI_FIN,
        output ACK0, ACK1, GNT0, GNT1, SPI_EN, SPI_DATA, DC, BUSY, ERR
    );

    modport master (
        output REQ0, REQ1, DAT0, DAT1, DC0, DC1, LOCK0, LOCK1, SPI_FIN,
        input  ACK0, ACK1, GNT0, GNT1, SPI_EN, SPI_DATA, DC, BUSY, ERR
    );

endinterface

// File: rtl/oled_arb_pick.sv
// Combinational winner select between the two requesters (1 = port 1).
// OLED_ARB_RR_EN selects round-robin on contention; otherwise port 0 always wins.
module oled_arb_pick
    import oled_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
`ifdef OLED_ARB_RR_EN
    input  logic last_i,
`endif
    output logic win_o_c
);

`ifdef OLED_ARB_RR_EN
    // On contention serve whoever was not served last.
    always_comb begin
        win_o_c = 1'(PORT0);
        if (req0_i && req1_i) begin
            win_o_c = ~last_i;
        end else if (req1_i) begin
            win_o_c = 1'(PORT1);
        end
    end
`else
    always_comb begin
        win_o_c = 1'(PORT0);
        if (!req0_i && req1_i) begin
            win_o_c = 1'(PORT1);
        end
    end
`endif

endmodule

// File: rtl/oled_spi_arbiter.sv
// Two-port arbiter sequencing a shared external SPI byte engine for an OLED.
// Optional OLED_ARB_RR_EN: round-robin instead of fixed priority to port 0.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    oled_spi_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_brk_q;
    logic             spi_en_q;
    oled_byte_t       data_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             busy_q;
    logic             err_q;

    oled_byte_t byte0_c;
    oled_byte_t byte1_c;
    oled_byte_t win_byte_c;
    oled_byte_t own_byte_c;
    logic       win_c;
    logic       own_req_c;
    logic       own_lock_c;

    assign byte0_c    = '{dat: bus.DAT0, dc: bus.DC0};
    assign byte1_c    = '{dat: bus.DAT1, dc: bus.DC1};
    assign win_byte_c = (win_c == 1'(PORT1)) ? byte1_c : byte0_c;
    assign own_byte_c = (owner_q == 1'(PORT1)) ? byte1_c : byte0_c;
    assign own_req_c  = (owner_q == 1'(PORT1)) ? bus.REQ1 : bus.REQ0;
    assign own_lock_c = (owner_q == 1'(PORT1)) ? bus.LOCK1 : bus.LOCK0;

`ifdef OLED_ARB_RR_EN
    logic last_q;

    oled_arb_pick u_pick (
        .req0_i  (bus.REQ0),
        .req1_i  (bus.REQ1),
        .last_i  (last_q),
        .win_o_c (win_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= 1'(PORT1);
        end else if (state_q == ST_IDLE && (bus.REQ0 || bus.REQ1)) begin
            last_q <= win_c;
        end
    end
`else
    oled_arb_pick u_pick (
        .req0_i  (bus.REQ0),
        .req1_i  (bus.REQ1),
        .win_o_c (win_c)
    );
`endif

    // Sequencer: IDLE -> SEND -> CLEAR -> (SEND on locked burst | IDLE).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'(PORT0);
            cnt_q      <= '0;
            lock_brk_q <= 1'b0;
            spi_en_q   <= 1'b0;
            data_q     <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.REQ0 || bus.REQ1) begin
                        owner_q  <= win_c;
                        data_q   <= win_byte_c;
                        gnt0_q   <= (win_c == 1'(PORT0));
                        gnt1_q   <= (win_c == 1'(PORT1));
                        spi_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.SPI_FIN) begin
                        ack0_q   <= (owner_q == 1'(PORT0));
                        ack1_q   <= (owner_q == 1'(PORT1));
                        spi_en_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_CLEAR;
                    end else if (cnt_q == CNT_LAST) begin
                        // Engine hung: abort without ACK and refuse burst continuation.
                        err_q      <= 1'b1;
                        lock_brk_q <= 1'b1;
                        spi_en_q   <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_CLEAR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (!bus.SPI_FIN) begin
                        lock_brk_q <= 1'b0;
                        if (!lock_brk_q && own_lock_c && own_req_c) begin
                            data_q   <= own_byte_c;
                            spi_en_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= ST_SEND;
                        end else begin
                            gnt0_q  <= 1'b0;
                            gnt1_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SPI_EN   = spi_en_q;
    assign bus.SPI_DATA = data_q.dat;
    assign bus.DC       = data_q.dc;
    assign bus.GNT0     = gnt0_q;
    assign bus.GNT1     = gnt1_q;
    assign bus.ACK0     = ack0_q;
    assign bus.ACK1     = ack1_q;
    assign bus.BUSY     = busy_q;
    assign bus.ERR      = err_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Randomized bench: two byte-queue requesters and an engine model with random
// FIN latency, hold time and hangs, checked against transaction-level rules.
module tb_oled_spi_arbiter;
    import oled_pkg::*;

    localparam int unsigned TO_CYC  = 16;
    localparam int unsigned N_BYTES = 200;

    typedef struct packed {
        logic [7:0] dat;
        logic       dc;
        logic       lock;
    } item_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    oled_spi_arbiter_if bus ();

    oled_spi_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    item_t q0[$];
    item_t q1[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    err_exp = 1'b0;
    bit    last_srv = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.dat  = 8'($urandom);
        it.dc   = 1'($urandom);
        it.lock = ($urandom_range(0, 2) == 0);
        return it;
    endfunction

    // Each requester presents the head of its queue while the queue is non-empty.
    task automatic drive_reqs();
        bus.REQ0  = (q0.size() != 0);
        bus.LOCK0 = 1'b0;
        if (q0.size() != 0) begin
            bus.DAT0  = q0[0].dat;
            bus.DC0   = q0[0].dc;
            bus.LOCK0 = q0[0].lock;
        end
        bus.REQ1  = (q1.size() != 0);
        bus.LOCK1 = 1'b0;
        if (q1.size() != 0) begin
            bus.DAT1  = q1[0].dat;
            bus.DC1   = q1[0].dc;
            bus.LOCK1 = q1[0].lock;
        end
    endtask

    task automatic refill();
        int n0 = $urandom_range(0, 4);
        int n1 = $urandom_range(0, 4);
        if (n0 + n1 == 0) n0 = 1;
        repeat (n0) q0.push_back(rand_item());
        repeat (n1) q1.push_back(rand_item());
    endtask

    // Arbitration rule from IDLE: 1 means port 1 wins.
    function automatic bit exp_winner(input bit r0, input bit r1);
`ifdef OLED_ARB_RR_EN
        if (r0 && r1) return !last_srv;
`endif
        return !r0 && r1;
    endfunction

    task automatic chk_owned(input bit own, input item_t it);
        chk("gnt0", 32'(bus.GNT0), 32'(!own));
        chk("gnt1", 32'(bus.GNT1), 32'(own));
        chk("busy", 32'(bus.BUSY), 32'd1);
        chk("spi_data", 32'(bus.SPI_DATA), 32'(it.dat));
        chk("dc", 32'(bus.DC), 32'(it.dc));
        chk("err", 32'(bus.ERR), 32'(err_exp));
    endtask

    task automatic chk_no_ack(input string tag);
        chk({tag, "_ack0"}, 32'(bus.ACK0), 32'd0);
        chk({tag, "_ack1"}, 32'(bus.ACK1), 32'd0);
    endtask

    initial begin
        bit    own;
        bit    prev_own;
        bit    cont;
        bit    tmo;
        item_t it;
        int    d;
        int    e;

        bus.REQ0 = 1'b0;  bus.REQ1 = 1'b0;
        bus.DAT0 = 8'h00; bus.DAT1 = 8'h00;
        bus.DC0  = 1'b0;  bus.DC1  = 1'b0;
        bus.LOCK0 = 1'b0; bus.LOCK1 = 1'b0;
        bus.SPI_FIN = 1'b0;
        prev_own = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_spi_en", 32'(bus.SPI_EN), 32'd0);
        chk("rst_spi_data", 32'(bus.SPI_DATA), 32'h00);
        chk("rst_dc", 32'(bus.DC), 32'd0);
        chk("rst_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk_no_ack("rst");

        RST = 1'b0;
        refill();
        drive_reqs();
        @(negedge CLK);
        chk("first_send", 32'(bus.SPI_EN), 32'd1);
        cont = 1'b0;

        for (int b = 0; b < int'(N_BYTES); b++) begin
            // Here SPI_EN has just risen for a new byte.
            own = cont ? prev_own : exp_winner(q0.size() != 0, q1.size() != 0);
            last_srv = own;
            it = own ? q1[0] : q0[0];
            chk("spi_en_rise", 32'(bus.SPI_EN), 32'd1);
            chk_owned(own, it);

            // Owner may drop REQ mid-send; the byte must still complete.
            if ($urandom_range(0, 3) == 0) begin
                if (own) bus.REQ1 = 1'b0;
                else     bus.REQ0 = 1'b0;
            end

            tmo = ($urandom_range(0, 11) == 0);
            if (tmo) begin
                repeat (TO_CYC - 1) begin
                    @(negedge CLK);
                    chk("tmo_send_hold", 32'(bus.SPI_EN), 32'd1);
                    chk_no_ack("tmo_send");
                    chk_owned(own, it);
                end
                @(negedge CLK);
                err_exp = 1'b1;
                chk("tmo_spi_en", 32'(bus.SPI_EN), 32'd0);
                chk("tmo_err", 32'(bus.ERR), 32'd1);
                chk_no_ack("tmo");
                drive_reqs();
                @(negedge CLK);
                chk("tmo_idle", 32'(bus.BUSY), 32'd0);
                chk("tmo_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
                chk("tmo_dc_hold", 32'(bus.DC), 32'(it.dc));
                chk("tmo_err_sticky", 32'(bus.ERR), 32'd1);
                cont = 1'b0;
            end else begin
                d = $urandom_range(1, 8);
                repeat (d - 1) begin
                    @(negedge CLK);
                    chk("send_hold", 32'(bus.SPI_EN), 32'd1);
                    chk_no_ack("send");
                    chk_owned(own, it);
                end
                bus.SPI_FIN = 1'b1;
                @(negedge CLK);
                chk("ack_owner", 32'(own ? bus.ACK1 : bus.ACK0), 32'd1);
                chk("ack_other", 32'(own ? bus.ACK0 : bus.ACK1), 32'd0);
                chk("ack_spi_en", 32'(bus.SPI_EN), 32'd0);
                chk_owned(own, it);
                if (own) void'(q1.pop_front());
                else     void'(q0.pop_front());
                drive_reqs();

                e = $urandom_range(0, 5);
                repeat (e) begin
                    @(negedge CLK);
                    chk("clear_spi_en", 32'(bus.SPI_EN), 32'd0);
                    chk_no_ack("clear");
                    chk_owned(own, it);
                end
                bus.SPI_FIN = 1'b0;
                cont = own ? (q1.size() != 0 && q1[0].lock) : (q0.size() != 0 && q0[0].lock);
                @(negedge CLK);
                if (cont) begin
                    chk("burst_next", 32'(bus.SPI_EN), 32'd1);
                end else begin
                    chk("clear_exit", 32'(bus.BUSY), 32'd0);
                    chk("exit_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
                    chk("dc_hold", 32'(bus.DC), 32'(it.dc));
                    chk("data_hold", 32'(bus.SPI_DATA), 32'(it.dat));
                    chk_no_ack("exit");
                end
            end

            if (!cont) begin
                if (q0.size() == 0 && q1.size() == 0) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(negedge CLK);
                        chk("idle_busy", 32'(bus.BUSY), 32'd0);
                        chk("idle_spi_en", 32'(bus.SPI_EN), 32'd0);
                    end
                    refill();
                    drive_reqs();
                end
                @(negedge CLK);
                chk("arb_latency", 32'(bus.SPI_EN), 32'd1);
            end
            prev_own = own;
        end

        // Reset in the middle of a send aborts everything, including ERR.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_send_spi_en", 32'(bus.SPI_EN), 32'd0);
        chk("rst_send_gnt", 32'({bus.GNT1, bus.GNT0}), 32'd0);
        chk("rst_send_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_send_err", 32'(bus.ERR), 32'd0);
        chk_no_ack("rst_send");
        q0.delete();
        q1.delete();
        drive_reqs();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("post_rst_idle", 32'(bus.BUSY), 32'd0);
        chk_no_ack("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_spi_arbiter.md
OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

Interface
REQ-001 Clock CLK; reset RST, synchronous, active-high.
REQ-002 Parameter TIMEOUT_CYC, default 4096: max cycles in SEND awaiting SPI_FIN before abort.
REQ-003 CLK  in  1  system clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 REQ0/REQ1  in  1 each  requester n holds high with DATn/DCn stable until ACKn.
REQ-006 DAT0/DAT1  in  8 each  byte to transmit.
REQ-007 DC0/DC1  in  1 each  data/command select for that byte.
REQ-008 LOCK0/LOCK1  in  1 each  owner keeps grant for the next byte (burst).
REQ-009 ACK0/ACK1  out  1 each  one-cycle pulse: byte fully shifted.
REQ-010 GNT0/GNT1  out  1 each  requester n owns the SPI engine; never both high.
REQ-011 SPI_EN  out  1  enable to shared SPI byte engine.
REQ-012 SPI_DATA  out  8  byte to shared SPI engine.
REQ-013 SPI_FIN  in  1  engine done; stays high until SPI_EN drops.
REQ-014 DC  out  1  OLED D/C pin, from owner's latched DCn.
REQ-015 BUSY  out  1  high in any state except IDLE.
REQ-016 ERR  out  1  sticky: a timeout occurred.

Function
REQ-017 States IDLE, SEND, CLEAR; SPI_EN high only in SEND.
REQ-018 IDLE, any REQn high: pick winner (REQ-030), latch DATn->SPI_DATA, DCn->DC, assert GNTn, next state SEND.
REQ-019 SEND: SPI_EN=1; timeout counter increments each cycle.
REQ-020 SEND with SPI_FIN=1: pulse ACKn for exactly one cycle, go CLEAR; counter reset.
REQ-021 CLEAR: SPI_EN=0; stay until SPI_FIN=0.
REQ-022 CLEAR exit, owner LOCKn=1 and REQn=1: re-latch DATn/DCn, keep GNTn, go SEND directly (other requester cannot intervene).
REQ-023 CLEAR exit otherwise: drop GNTn, go IDLE; arbitration on next IDLE cycle.
REQ-024 Minimum per-byte overhead: IDLE->SEND 1 cycle, SEND->CLEAR 1 cycle after SPI_FIN rise, CLEAR->next 1 cycle after SPI_FIN fall.
REQ-025 Counter reaching TIMEOUT_CYC-1 in SEND without SPI_FIN: set ERR, no ACK, go CLEAR, lock broken (next exit to IDLE).
REQ-026 REQn dropped by owner mid-SEND: ignored; byte completes, ACKn still pulses.
REQ-027 SPI_DATA and DC stable from latch until next latch; DC holds last value in IDLE.
REQ-028 Counter width clog2(TIMEOUT_CYC); no wrap before abort.

Reset
REQ-029 RST: state IDLE, SPI_EN=0, SPI_DATA=8'h00, DC=0, GNT0/1=0, ACK0/1=0, BUSY=0, ERR=0, counter 0, last-served=1; RST mid-SEND aborts without ACK.

Configuration
REQ-030 OLED_ARB_RR_EN defined: simultaneous REQ0/REQ1 in IDLE grant the requester not last served; last-served updates on each grant. Undefined: REQ0 always wins (fixed priority, init sequencer on port 0); last-served logic absent.

Structure
REQ-031 Shared package oled_pkg holds state encoding, port-index constants, default TIMEOUT_CYC.
REQ-032 One sub-module oled_arb_pick: combinational winner select from REQ0/REQ1/last-served, compiled per OLED_ARB_RR_EN.
REQ-033 The SPI byte engine stays external; this block only sequences it.

Verification
REQ-034 REQ0 alone, DAT0=8'hAE, DC0=0; engine model FIN after 16 cycles -> SPI_DATA=AE, DC=0, one ACK0, GNT1 never high.
REQ-035 REQ0/REQ1 same cycle, DAT0=8'h8D, DAT1=8'h55 held -> fixed: 8D,8D,... port 0 starves 1 while held; RR: 8D then 55 then 8D.
REQ-036 LOCK1=1, three bytes 81,0F,A1 from port 1 with REQ0 high throughout -> all three sent back-to-back, GNT1 continuous, then GNT0.
REQ-037 TIMEOUT_CYC=8, engine never raises FIN -> ERR=1 at cycle 8 of SEND, no ACK, return IDLE, ERR stays until RST.
REQ-038 RST asserted in SEND -> next cycle SPI_EN=0, GNT=0, BUSY=0, ERR=0, no ACK.
REQ-039 SPI_FIN held high 5 cycles after SPI_EN drop -> state stays CLEAR 5 cycles, no second ACK, no new latch.
